fft_frame_sched: RTL and testbench

Frame scheduler for the FFT spectrum path. It gates exactly one FFT frame of input samples into the magnitude core and waits for the magnitude write to the spectrum RAM to finish. It then triggers one detection/RAM traversal pass and enforces a holdoff before the next frame. It replaces the free-running capture gate ahead of fft_full_magni. It also discards frames whose mixer step changed mid-capture.

---
 rtl/fft_frame_sched_if.sv | 23 ++
 rtl/fft_frame_sched.sv | 103 ++++++++++
 tb/tb_fft_frame_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if: capture gate, magnitude, traversal and status signals of the FFT frame scheduler.
interface fft_frame_sched_if;
  logic        s_run_en;
  logic        s_sample_valid;
  logic        m_fft_gate;
  logic        s_mag_valid;
  logic [15:0] s_mag_addr;
  logic        m_trav_start;
  logic        s_trav_done;
  logic [6:0]  s_config_step;
  logic        m_frame_done;
  logic [15:0] m_frame_cnt;
  logic [7:0]  m_err_cnt;
  logic [2:0]  m_state;
  modport master (
    input  s_run_en, s_sample_valid, s_mag_valid, s_mag_addr, s_trav_done, s_config_step,
    output m_fft_gate, m_trav_start, m_frame_done, m_frame_cnt, m_err_cnt, m_state
  );
  modport slave (
    output s_run_en, s_sample_valid, s_mag_valid, s_mag_addr, s_trav_done, s_config_step,
    input  m_fft_gate, m_trav_start, m_frame_done, m_frame_cnt, m_err_cnt, m_state
  );
endinterface

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: gates one FFT frame into the magnitude core, waits for its magnitudes,
// triggers one detector traversal and enforces a holdoff; frames with a mid-capture step change are dropped.
module fft_frame_sched #(
  parameter int FFT_LEN        = 16384,
  parameter int HOLDOFF_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic               sys_clk,
  input logic               sys_rstn,
  fft_frame_sched_if.master bus
);
  localparam int SW = $clog2(FFT_LEN);
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, CAPTURE = 3'd1, WAIT_MAG = 3'd2, TRAV = 3'd3, HOLDOFF = 3'd4} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [6:0]      step_latch_q, step_latch_d;
  logic            stale_q, stale_d, trav_start_q, trav_start_d, frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d, err_inc;
  logic            accept, step_diff, mag_last, tmo_hit, hold_done;
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      hold_q       <= '0;
      tmo_q        <= '0;
      step_latch_q <= '0;
      stale_q      <= 1'b0;
      trav_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      step_latch_q <= step_latch_d;
      stale_q      <= stale_d;
      trav_start_q <= trav_start_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
  always_comb begin
    accept       = bus.s_sample_valid && state_q == CAPTURE;
    step_diff    = bus.s_config_step != step_latch_q;
    mag_last     = bus.s_mag_valid && bus.s_mag_addr == 16'(FFT_LEN - 1);
    tmo_hit      = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    hold_done    = HOLDOFF_CYCLES <= 1 || hold_q == HW'(HOLDOFF_CYCLES - 1);
    err_inc      = err_cnt_q + (err_cnt_q != 8'hff ? 8'd1 : 8'd0);
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    step_latch_d = step_latch_q;
    stale_d      = stale_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    trav_start_d = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:     state_d = bus.s_run_en ? CAPTURE : IDLE;
      CAPTURE: begin
        sample_cnt_d = accept ? sample_cnt_q + 1'b1 : sample_cnt_q;
        state_d      = accept && sample_cnt_q == SW'(FFT_LEN - 1) ? WAIT_MAG : CAPTURE;
      end
      WAIT_MAG: begin
        // a step change seen on the very cycle of the last magnitude still spoils the frame
        state_d      = mag_last ? (stale_q || step_diff ? HOLDOFF : TRAV) : (tmo_hit ? HOLDOFF : WAIT_MAG);
        trav_start_d = mag_last && !(stale_q || step_diff);
        err_cnt_d    = state_d == HOLDOFF ? err_inc : err_cnt_q;
      end
      TRAV: begin
        state_d      = bus.s_trav_done || tmo_hit ? HOLDOFF : TRAV;
        frame_done_d = bus.s_trav_done;
        frame_cnt_d  = bus.s_trav_done ? frame_cnt_q + 1'b1 : frame_cnt_q;
        err_cnt_d    = !bus.s_trav_done && tmo_hit ? err_inc : err_cnt_q;
      end
      HOLDOFF:  state_d = hold_done ? (bus.s_run_en ? CAPTURE : IDLE) : HOLDOFF;
      default:  state_d = IDLE;
    endcase
    stale_d = (state_q == CAPTURE || state_q == WAIT_MAG) && step_diff ? 1'b1 : stale_d;
    if (state_d == CAPTURE && state_q != CAPTURE) begin
      step_latch_d = bus.s_config_step;
      stale_d      = 1'b0;
      sample_cnt_d = '0;
    end
    tmo_d  = state_d != state_q ? '0 : tmo_q + 1'b1;
    hold_d = state_d != state_q ? '0 : hold_q + 1'b1;
  end
  always_comb begin
    bus.m_fft_gate   = state_q == CAPTURE;
    bus.m_state      = state_q;
    bus.m_trav_start = trav_start_q;
    bus.m_frame_done = frame_done_q;
    bus.m_frame_cnt  = frame_cnt_q;
    bus.m_err_cnt    = err_cnt_q;
  end
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed frames; expected events are queued by the stimulus and
// popped by an independent monitor watching gate closures, trav_start, frame_done and err_cnt.
module tb_fft_frame_sched;
  localparam int EV_GATE = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_CAP = 3'd1, S_WMAG = 3'd2, S_TRAV = 3'd3, S_HOLD = 3'd4;
  typedef struct { int kind; int val; } ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  ev_t exp_q[$];
  fft_frame_sched_if bus();
  fft_frame_sched #(.FFT_LEN(16), .HOLDOFF_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .sys_clk(clk), .sys_rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask
  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0d, expected none at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", val, e.val);
    end
  endtask
  initial begin : monitor
    int acc = 0;
    logic gate_prev = 1'b0;
    logic [7:0] err_prev = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        acc = 0;
        gate_prev = 1'b0;
        err_prev = bus.m_err_cnt;
      end else begin
        if (bus.m_fft_gate && bus.s_sample_valid) acc++;
        if (gate_prev && !bus.m_fft_gate) begin
          observe(EV_GATE, acc);
          acc = 0;
        end
        gate_prev = bus.m_fft_gate;
        if (bus.m_trav_start) observe(EV_START, 0);
        if (bus.m_frame_done) observe(EV_DONE, bus.m_frame_cnt * 256 + bus.m_err_cnt);
        if (bus.m_err_cnt != err_prev) observe(EV_ERR, bus.m_err_cnt);
        err_prev = bus.m_err_cnt;
      end
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s, input int bound);
    int n = 0;
    while (bus.m_state != s && n < bound) begin
      tick();
      n++;
    end
    check("wait_state", bus.m_state, s);
  endtask
  task automatic capture(input int per, input int chg_at, input logic [6:0] new_step);
    int c = 0;
    int k = 0;
    wait_state(S_CAP, 300);
    while (bus.m_fft_gate && c < 400) begin
      bus.s_sample_valid = (c % per) == 0;
      if (bus.s_sample_valid && k == chg_at) bus.s_config_step = new_step;
      if (bus.s_sample_valid) k++;
      tick();
      c++;
    end
    bus.s_sample_valid = 1'b1;
    check("gate_low", bus.m_fft_gate, 0);
  endtask
  task automatic mag_stream(input int last);
    for (int a = 0; a <= last; a++) begin
      bus.s_mag_valid = 1'b1;
      bus.s_mag_addr = 16'(a);
      tick();
    end
    bus.s_mag_valid = 1'b0;
  endtask
  task automatic trav_finish(input int delay);
    repeat (delay) tick();
    bus.s_trav_done = 1'b1;
    tick();
    bus.s_trav_done = 1'b0;
  endtask
  initial begin : stim
    int n;
    int exp_err;
    bus.s_run_en = 1'b0;
    bus.s_sample_valid = 1'b0;
    bus.s_mag_valid = 1'b0;
    bus.s_mag_addr = '0;
    bus.s_trav_done = 1'b0;
    bus.s_config_step = 7'd5;
    repeat (3) tick();
    check("rst_state", bus.m_state, S_IDLE);
    check("rst_gate", bus.m_fft_gate, 0);
    check("rst_frame_cnt", bus.m_frame_cnt, 0);
    check("rst_err_cnt", bus.m_err_cnt, 0);
    check("rst_trav_start", bus.m_trav_start, 0);
    rstn = 1'b1;
    tick();
    check("idle_hold", bus.m_state, S_IDLE);
    // nominal frame, then holdoff length
    bus.s_run_en = 1'b1;
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 1 * 256 + 0);
    capture(1, -1, 7'd0);
    mag_stream(15);
    trav_finish(9);
    check("hold_entry", bus.m_state, S_HOLD);
    n = 0;
    while (bus.m_state == S_HOLD && n < 50) begin tick(); n++; end
    check("holdoff_cycles", n, 4);
    check("recapture", bus.m_state, S_CAP);
    // bursty input
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 2 * 256 + 0);
    capture(3, -1, 7'd0);
    mag_stream(15);
    trav_finish(4);
    // step change mid-capture spoils the frame
    push(EV_GATE, 16); push(EV_ERR, 1);
    capture(1, 8, 7'd6);
    mag_stream(15);
    check("stale_to_hold", bus.m_state, S_HOLD);
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 3 * 256 + 1);
    capture(1, -1, 7'd0);
    mag_stream(15);
    trav_finish(2);
    // timeout in WAIT_MAG, stray trav_done in HOLDOFF ignored
    push(EV_GATE, 16); push(EV_ERR, 2);
    capture(1, -1, 7'd0);
    n = 0;
    while (bus.m_state == S_WMAG && n < 200) begin
      bus.s_mag_valid = n < 15;
      bus.s_mag_addr = 16'(n);
      tick();
      n++;
    end
    bus.s_mag_valid = 1'b0;
    check("wait_mag_cycles", n, 64);
    bus.s_trav_done = 1'b1;
    tick();
    bus.s_trav_done = 1'b0;
    // run_en dropped in TRAV completes the frame then parks in IDLE
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 4 * 256 + 2);
    capture(1, -1, 7'd0);
    mag_stream(15);
    bus.s_run_en = 1'b0;
    trav_finish(3);
    wait_state(S_IDLE, 20);
    repeat (3) tick();
    check("idle_stays", bus.m_state, S_IDLE);
    check("idle_gate", bus.m_fft_gate, 0);
    // asynchronous reset mid-capture
    bus.s_run_en = 1'b1;
    wait_state(S_CAP, 10);
    repeat (5) tick();
    #3 rstn = 1'b0;
    #1;
    check("arst_gate", bus.m_fft_gate, 0);
    check("arst_state", bus.m_state, S_IDLE);
    check("arst_frame_cnt", bus.m_frame_cnt, 0);
    check("arst_err_cnt", bus.m_err_cnt, 0);
    tick();
    tick();
    rstn = 1'b1;
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 1 * 256 + 0);
    capture(1, -1, 7'd0);
    mag_stream(15);
    trav_finish(3);
    // trav_done on the timeout cycle counts as success
    push(EV_GATE, 16); push(EV_START, 0); push(EV_DONE, 2 * 256 + 0);
    capture(1, -1, 7'd0);
    mag_stream(15);
    repeat (63) tick();
    trav_finish(0);
    // error counter saturation
    exp_err = 0;
    for (int i = 0; i < 260; i++) begin
      push(EV_GATE, 16);
      if (exp_err < 255) begin
        exp_err++;
        push(EV_ERR, exp_err);
      end
      capture(1, -1, 7'd0);
      wait_state(S_HOLD, 100);
    end
    check("err_saturated", bus.m_err_cnt, 255);
    check("frame_cnt_kept", bus.m_frame_cnt, 2);
    bus.s_run_en = 1'b0;
    wait_state(S_IDLE, 20);
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
